// File: rtl/id_ex_forward_stage_pkg.sv
// Shared encodings for the ID/EX stage: operand-mux selects and hazard FSM states.
package id_ex_forward_stage_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

endpackage

// File: rtl/id_ex_forward_stage_forwarding_unit.sv
// Combinational operand-forwarding selects for the two EX-stage operand muxes.
// The younger EX/MEM result wins over MEM/WB; register 0 is never forwarded.
module id_ex_forward_stage_forwarding_unit
  import id_ex_forward_stage_pkg::*;
#(
  parameter int NRegBits = 5
) (
  input  logic                ex_valid_i,
  input  logic [NRegBits-1:0] ex_rs_i,
  input  logic [NRegBits-1:0] ex_rt_i,
  input  logic                exmem_reg_write_i,
  input  logic [NRegBits-1:0] exmem_write_reg_i,
  input  logic                memwb_reg_write_i,
  input  logic [NRegBits-1:0] memwb_write_reg_i,
  output logic [1:0]          forward_a_o,
  output logic [1:0]          forward_b_o
);

  logic exmem_live;
  logic memwb_live;

  always_comb begin
    exmem_live  = exmem_reg_write_i && (exmem_write_reg_i != '0);
    memwb_live  = memwb_reg_write_i && (memwb_write_reg_i != '0);
    forward_a_o = FWD_REG;
    forward_b_o = FWD_REG;
    if (ex_valid_i) begin
      if (exmem_live && (exmem_write_reg_i == ex_rs_i)) begin
        forward_a_o = FWD_EXMEM;
      end else if (memwb_live && (memwb_write_reg_i == ex_rs_i)) begin
        forward_a_o = FWD_MEMWB;
      end
      if (exmem_live && (exmem_write_reg_i == ex_rt_i)) begin
        forward_b_o = FWD_EXMEM;
      end else if (memwb_live && (memwb_write_reg_i == ex_rt_i)) begin
        forward_b_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with load-use hazard detection, one-cycle stall FSM,
// bubble injection on stall/flush, operand forwarding and a saturating stall counter.
module id_ex_forward_stage
  import id_ex_forward_stage_pkg::*;
#(
  parameter int NBits    = 32,
  parameter int NRegBits = 5,
  parameter int NCtrl    = 12,
  parameter int NCnt     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ID_Valid_i,
  input  logic [NBits-1:0]    ID_ReadData1_i,
  input  logic [NBits-1:0]    ID_ReadData2_i,
  input  logic [NRegBits-1:0] ID_Rs_i,
  input  logic [NRegBits-1:0] ID_Rt_i,
  input  logic [NRegBits-1:0] ID_WriteReg_i,
  input  logic                ID_MemRead_i,
  input  logic                ID_RegWrite_i,
  input  logic [NCtrl-1:0]    ID_Ctrl_i,
  input  logic                Flush_i,
  input  logic                EXMEM_RegWrite_i,
  input  logic [NRegBits-1:0] EXMEM_WriteReg_i,
  input  logic                MEMWB_RegWrite_i,
  input  logic [NRegBits-1:0] MEMWB_WriteReg_i,
  output logic                EX_Valid_o,
  output logic [NBits-1:0]    EX_ReadData1_o,
  output logic [NBits-1:0]    EX_ReadData2_o,
  output logic [NRegBits-1:0] EX_Rs_o,
  output logic [NRegBits-1:0] EX_Rt_o,
  output logic [NRegBits-1:0] EX_WriteReg_o,
  output logic                EX_MemRead_o,
  output logic                EX_RegWrite_o,
  output logic [NCtrl-1:0]    EX_Ctrl_o,
  output logic [1:0]          ForwardA_o,
  output logic [1:0]          ForwardB_o,
  output logic                Stall_o,
  output logic [NCnt-1:0]     StallCount_o,
  output state_e              dbg_state_o
);

  localparam logic [NCnt-1:0] CntOne = NCnt'(1);

  logic                valid_q, valid_d;
  logic [NBits-1:0]    rd1_q, rd1_d;
  logic [NBits-1:0]    rd2_q, rd2_d;
  logic [NRegBits-1:0] rs_q, rs_d;
  logic [NRegBits-1:0] rt_q, rt_d;
  logic [NRegBits-1:0] wr_q, wr_d;
  logic                mem_read_q, mem_read_d;
  logic                reg_write_q, reg_write_d;
  logic [NCtrl-1:0]    ctrl_q, ctrl_d;
  logic [NCnt-1:0]     cnt_q, cnt_d;
  state_e              state_q, state_d;
  logic                haz;
  logic                stall;

  // Load in EX whose destination is a source of the instruction in ID.
  always_comb begin
    haz = ID_Valid_i && valid_q && mem_read_q && (wr_q != '0) &&
          ((wr_q == ID_Rs_i) || (wr_q == ID_Rt_i));
    stall = haz && !Flush_i && (state_q == ST_RUN);
  end

  always_comb begin
    valid_d     = ID_Valid_i;
    rd1_d       = ID_ReadData1_i;
    rd2_d       = ID_ReadData2_i;
    rs_d        = ID_Rs_i;
    rt_d        = ID_Rt_i;
    wr_d        = ID_WriteReg_i;
    mem_read_d  = ID_MemRead_i;
    reg_write_d = ID_RegWrite_i;
    ctrl_d      = ID_Ctrl_i;
    if (Flush_i || stall) begin
      valid_d     = 1'b0;
      rd1_d       = '0;
      rd2_d       = '0;
      rs_d        = '0;
      rt_d        = '0;
      wr_d        = '0;
      mem_read_d  = 1'b0;
      reg_write_d = 1'b0;
      ctrl_d      = '0;
    end
    // STALL always returns to RUN; stall can only fire from RUN.
    state_d = stall ? ST_STALL : ST_RUN;
    cnt_d   = (stall && (cnt_q != '1)) ? (cnt_q + CntOne) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      wr_q        <= '0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
      ctrl_q      <= '0;
      cnt_q       <= '0;
      state_q     <= ST_RUN;
    end else begin
      valid_q     <= valid_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      wr_q        <= wr_d;
      mem_read_q  <= mem_read_d;
      reg_write_q <= reg_write_d;
      ctrl_q      <= ctrl_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
    end
  end

  id_ex_forward_stage_forwarding_unit #(
    .NRegBits(NRegBits)
  ) u_fwd (
    .ex_valid_i        (valid_q),
    .ex_rs_i           (rs_q),
    .ex_rt_i           (rt_q),
    .exmem_reg_write_i (EXMEM_RegWrite_i),
    .exmem_write_reg_i (EXMEM_WriteReg_i),
    .memwb_reg_write_i (MEMWB_RegWrite_i),
    .memwb_write_reg_i (MEMWB_WriteReg_i),
    .forward_a_o       (ForwardA_o),
    .forward_b_o       (ForwardB_o)
  );

  assign EX_Valid_o     = valid_q;
  assign EX_ReadData1_o = rd1_q;
  assign EX_ReadData2_o = rd2_q;
  assign EX_Rs_o        = rs_q;
  assign EX_Rt_o        = rt_q;
  assign EX_WriteReg_o  = wr_q;
  assign EX_MemRead_o   = mem_read_q;
  assign EX_RegWrite_o  = reg_write_q;
  assign EX_Ctrl_o      = ctrl_q;
  assign Stall_o        = stall;
  assign StallCount_o   = cnt_q;
  assign dbg_state_o    = state_q;

endmodule
